// File: rtl/pe_pkg.sv
// Shared definitions for the PE stream feeder: FSM encoding, channel indices,
// default GLB region bases and the PE configuration payload.
package pe_pkg;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned NUM_CH = 3;

  localparam int unsigned CH_IFMAP  = 0;
  localparam int unsigned CH_WEIGHT = 1;
  localparam int unsigned CH_IPSUM  = 2;

  localparam int unsigned DEF_IFMAP_BASE  = 0;
  localparam int unsigned DEF_WEIGHT_BASE = 64;
  localparam int unsigned DEF_IPSUM_BASE  = 128;
  localparam int unsigned DEF_OPSUM_BASE  = 192;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] iw_size;
    logic [3:0] c;
    logic [3:0] f;
    logic [3:0] n;
    logic [3:0] o;
  } pe_cfg_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/stream_tx_slot.sv
// One transmit channel: a single-entry holding register fed from the GLB,
// issued/sent counters and the fetch request towards the shared read port.
module stream_tx_slot
  import pe_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             grant_i,
  input  logic [DW-1:0]    rdata_i,
  input  logic             ready_i,
  output logic             req_c_o,
  output logic [CNT_W-1:0] issued_o,
  output logic             enable_o,
  output logic [DW-1:0]    data_o,
  output logic             complete_c_o
);

  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    data_q, data_d;
  logic             xfer;

  // The read data of a granted fetch is captured at the end of the grant
  // cycle, so a read is only in flight during that cycle and a slot that
  // transfers every cycle can refill every cycle.
  always_comb begin
    xfer     = valid_q & ready_i;
    req_c_o  = run_i && (issued_q < len_i) && (!valid_q || xfer);
    issued_d = issued_q;
    sent_d   = sent_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (clear_i) begin
      issued_d = '0;
      sent_d   = '0;
      valid_d  = 1'b0;
      data_d   = '0;
    end else begin
      if (xfer) begin
        sent_d  = cnt_inc(sent_q);
        valid_d = 1'b0;
      end
      if (grant_i) begin
        issued_d = cnt_inc(issued_q);
        valid_d  = 1'b1;
        data_d   = rdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      sent_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      issued_q <= issued_d;
      sent_q   <= sent_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Counts the transfer happening this cycle so RUN can end on the last word.
  assign complete_c_o = ((sent_q + CNT_W'(xfer)) == len_i);
  assign issued_o     = issued_q;
  assign enable_o     = valid_q;
  assign data_o       = data_q;

endmodule

// File: rtl/pe_stream_feeder.sv
// GLB-side feeder for one row-stationary PE: streams ifmap/weight/ipsum words
// from the shared GLB read port and writes the returned opsum stream back.
module pe_stream_feeder
  import pe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       PSUM_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] IFMAP_BASE  = ADDR_W'(DEF_IFMAP_BASE),
  parameter logic [ADDR_W-1:0] WEIGHT_BASE = ADDR_W'(DEF_WEIGHT_BASE),
  parameter logic [ADDR_W-1:0] IPSUM_BASE  = ADDR_W'(DEF_IPSUM_BASE),
  parameter logic [ADDR_W-1:0] OPSUM_BASE  = ADDR_W'(DEF_OPSUM_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        ifmap_len,
  input  logic [5:0]        weight_len,
  input  logic [4:0]        psum_len,
  input  logic [3:0]        cfg_iw_size,
  input  logic [3:0]        cfg_c,
  input  logic [3:0]        cfg_f,
  input  logic [3:0]        cfg_n,
  input  logic [3:0]        cfg_o,
  output logic [3:0]        iw_size,
  output logic [3:0]        c,
  output logic [3:0]        f,
  output logic [3:0]        n,
  output logic [3:0]        o,
  output logic              busy,
  output logic              done,
  output logic              glb_ren,
  output logic [ADDR_W-1:0] glb_raddr,
  input  logic [PSUM_W-1:0] glb_rdata,
  output logic              glb_wen,
  output logic [ADDR_W-1:0] glb_waddr,
  output logic [PSUM_W-1:0] glb_wdata,
  output logic              ifmap_enable,
  output logic [DATA_W-1:0] ifmap_data,
  input  logic              ifmap_ready,
  output logic              weight_enable,
  output logic [DATA_W-1:0] weight_data,
  input  logic              weight_ready,
  output logic              ipsum_enable,
  output logic [PSUM_W-1:0] ipsum_data,
  input  logic              ipsum_ready,
  input  logic              opsum_enable,
  input  logic [PSUM_W-1:0] opsum_data,
  output logic              opsum_ready
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ifmap_len_q, ifmap_len_d;
  logic [CNT_W-1:0] weight_len_q, weight_len_d;
  logic [CNT_W-1:0] psum_len_q, psum_len_d;
  logic [CNT_W-1:0] opsum_rcvd_q, opsum_rcvd_d;
  pe_cfg_t          cfg_q, cfg_d;

  logic              run_start;
  logic              in_run;
  logic              opsum_xfer;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] complete;
  logic [CNT_W-1:0]  issued_ifmap, issued_weight, issued_ipsum;

  assign in_run = (state_q == ST_RUN);

  stream_tx_slot #(.DW(DATA_W)) u_ifmap_slot (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (run_start),
    .run_i        (in_run),
    .len_i        (ifmap_len_q),
    .grant_i      (grant[CH_IFMAP]),
    .rdata_i      (DATA_W'(glb_rdata)),
    .ready_i      (ifmap_ready),
    .req_c_o      (req[CH_IFMAP]),
    .issued_o     (issued_ifmap),
    .enable_o     (ifmap_enable),
    .data_o       (ifmap_data),
    .complete_c_o (complete[CH_IFMAP])
  );

  stream_tx_slot #(.DW(DATA_W)) u_weight_slot (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (run_start),
    .run_i        (in_run),
    .len_i        (weight_len_q),
    .grant_i      (grant[CH_WEIGHT]),
    .rdata_i      (DATA_W'(glb_rdata)),
    .ready_i      (weight_ready),
    .req_c_o      (req[CH_WEIGHT]),
    .issued_o     (issued_weight),
    .enable_o     (weight_enable),
    .data_o       (weight_data),
    .complete_c_o (complete[CH_WEIGHT])
  );

  stream_tx_slot #(.DW(PSUM_W)) u_ipsum_slot (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (run_start),
    .run_i        (in_run),
    .len_i        (psum_len_q),
    .grant_i      (grant[CH_IPSUM]),
    .rdata_i      (glb_rdata),
    .ready_i      (ipsum_ready),
    .req_c_o      (req[CH_IPSUM]),
    .issued_o     (issued_ipsum),
    .enable_o     (ipsum_enable),
    .data_o       (ipsum_data),
    .complete_c_o (complete[CH_IPSUM])
  );

  // Single shared read port, fixed priority ipsum > weight > ifmap.
  always_comb begin
    grant     = '0;
    glb_ren   = 1'b0;
    glb_raddr = '0;
    if (req[CH_IPSUM]) begin
      grant[CH_IPSUM] = 1'b1;
      glb_ren         = 1'b1;
      glb_raddr       = IPSUM_BASE + ADDR_W'(issued_ipsum);
    end else if (req[CH_WEIGHT]) begin
      grant[CH_WEIGHT] = 1'b1;
      glb_ren          = 1'b1;
      glb_raddr        = WEIGHT_BASE + ADDR_W'(issued_weight);
    end else if (req[CH_IFMAP]) begin
      grant[CH_IFMAP] = 1'b1;
      glb_ren         = 1'b1;
      glb_raddr       = IFMAP_BASE + ADDR_W'(issued_ifmap);
    end
  end

  // Opsum write-back goes out in the same cycle as the PE handshake.
  always_comb begin
    opsum_ready = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                  (opsum_rcvd_q < psum_len_q);
    opsum_xfer  = opsum_enable && opsum_ready;
    glb_wen     = opsum_xfer;
    glb_waddr   = opsum_xfer ? (OPSUM_BASE + ADDR_W'(opsum_rcvd_q)) : '0;
    glb_wdata   = opsum_xfer ? opsum_data : '0;
  end

  always_comb begin
    state_d      = state_q;
    run_start    = 1'b0;
    ifmap_len_d  = ifmap_len_q;
    weight_len_d = weight_len_q;
    psum_len_d   = psum_len_q;
    cfg_d        = cfg_q;
    opsum_rcvd_d = opsum_rcvd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          run_start    = 1'b1;
          state_d      = ST_RUN;
          ifmap_len_d  = ifmap_len;
          weight_len_d = weight_len;
          psum_len_d   = CNT_W'(psum_len);
          cfg_d        = '{iw_size: cfg_iw_size, c: cfg_c, f: cfg_f,
                           n: cfg_n, o: cfg_o};
          opsum_rcvd_d = '0;
        end
      end
      ST_RUN: begin
        if (&complete) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (opsum_rcvd_q == psum_len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (opsum_xfer) opsum_rcvd_d = cnt_inc(opsum_rcvd_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifmap_len_q  <= '0;
      weight_len_q <= '0;
      psum_len_q   <= '0;
      cfg_q        <= '0;
      opsum_rcvd_q <= '0;
    end else begin
      ifmap_len_q  <= ifmap_len_d;
      weight_len_q <= weight_len_d;
      psum_len_q   <= psum_len_d;
      cfg_q        <= cfg_d;
      opsum_rcvd_q <= opsum_rcvd_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign iw_size = cfg_q.iw_size;
  assign c       = cfg_q.c;
  assign f       = cfg_q.f;
  assign n       = cfg_q.n;
  assign o       = cfg_q.o;

endmodule
